weight_loader: RTL and testbench

Streams one convolution kernel and its bias from the EPU weight SRAM into the EPU weight buffer. It drives that buffer's write side: it issues one 1-cycle-latency SRAM read per byte, then emits one write strobe per weight (5x5, 4x4 or 4x2 mode) and a final bias strobe. It sits between the EPU controller (start/done) and the weight buffer (strobe/data inputs).

---
 rtl/weight_loader_if.sv | 34 +++
 rtl/weight_loader.sv | 119 +++++++++++
 tb/tb_weight_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/weight_loader_if.sv
// Controller, SRAM and weight-buffer signals of the weight loader, grouped into one bundle.
// The master side is the surrounding system; the slave side is the loader itself.
interface weight_loader_if #(
    parameter int ADDR_W = 16
);
    logic              i_start;
    logic [1:0]        i_mode;
    logic [ADDR_W-1:0] i_base_addr;
    logic              i_hold;
    logic              o_mem_re;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [7:0]        i_mem_rdata;
    logic              o_weight_new;
    logic              o_weight_new_16;
    logic              o_weight_new_8;
    logic [7:0]        o_weight;
    logic              o_bias_new;
    logic [7:0]        o_bias;
    logic              o_busy;
    logic              o_done;
    logic              o_err;

    modport slave (
        input  i_start, i_mode, i_base_addr, i_hold, i_mem_rdata,
        output o_mem_re, o_mem_addr, o_weight_new, o_weight_new_16, o_weight_new_8,
               o_weight, o_bias_new, o_bias, o_busy, o_done, o_err
    );

    modport master (
        output i_start, i_mode, i_base_addr, i_hold, i_mem_rdata,
        input  o_mem_re, o_mem_addr, o_weight_new, o_weight_new_16, o_weight_new_8,
               o_weight, o_bias_new, o_bias, o_busy, o_done, o_err
    );
endinterface

// File: rtl/weight_loader.sv
// Streams one kernel (25/16/8 weights) plus its bias from the weight SRAM into the weight buffer.
// One read per byte; each returned byte is registered onto the strobe for the latched mode.
module weight_loader #(
    parameter int ADDR_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    weight_loader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q;
    logic [4:0]        n_q;
    logic [4:0]        k_q;
    logic              rd_vld_q;
    logic              rd_bias_q;
    logic [2:0]        wstb_q;
    logic [7:0]        weight_q;
    logic [7:0]        bias_q;
    logic              bias_new_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              issue_d;
    logic [ADDR_W-1:0] addr_d;

    // Hold must gate the read in the same cycle, so issue is decoded from state, not registered.
    assign issue_d = (state_q == S_FETCH) && !bus.i_hold;
    assign addr_d  = base_q + {{(ADDR_W-5){1'b0}}, k_q};

    assign bus.o_mem_re        = issue_d;
    assign bus.o_mem_addr      = issue_d ? addr_d : '0;
    assign bus.o_weight_new    = wstb_q[0];
    assign bus.o_weight_new_16 = wstb_q[1];
    assign bus.o_weight_new_8  = wstb_q[2];
    assign bus.o_weight        = weight_q;
    assign bus.o_bias_new      = bias_new_q;
    assign bus.o_bias          = bias_q;
    assign bus.o_busy          = busy_q;
    assign bus.o_done          = done_q;
    assign bus.o_err           = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            mode_q     <= 2'd0;
            base_q     <= '0;
            n_q        <= 5'd0;
            k_q        <= 5'd0;
            rd_vld_q   <= 1'b0;
            rd_bias_q  <= 1'b0;
            wstb_q     <= 3'b000;
            weight_q   <= 8'h00;
            bias_q     <= 8'h00;
            bias_new_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            wstb_q     <= 3'b000;
            bias_new_q <= 1'b0;

            // Read return pipeline: data arrives one cycle after issue and is registered out.
            rd_vld_q  <= issue_d;
            rd_bias_q <= issue_d && (k_q == n_q);
            if (rd_vld_q) begin
                if (rd_bias_q) begin
                    bias_q     <= bus.i_mem_rdata;
                    bias_new_q <= 1'b1;
                end else begin
                    weight_q <= bus.i_mem_rdata;
                    wstb_q   <= 3'b001 << mode_q;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (bus.i_start) begin
                        if (bus.i_mode == 2'd3) begin
                            err_q <= 1'b1;
                        end else begin
                            mode_q  <= bus.i_mode;
                            base_q  <= bus.i_base_addr;
                            n_q     <= (bus.i_mode == 2'd0) ? 5'd25 :
                                       (bus.i_mode == 2'd1) ? 5'd16 : 5'd8;
                            k_q     <= 5'd0;
                            busy_q  <= 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue_d) begin
                        k_q <= k_q + 5'd1;
                        if (k_q == n_q) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (bias_new_q) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
// Self-checking bench for weight_loader: table of directed loads plus random loads,
// each checked cycle by cycle against a timeline built from the load rules.
module tb_weight_loader;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    weight_loader_if #(.ADDR_W(16)) bus ();
    weight_loader #(.ADDR_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [0:65535];
    always @(posedge clk) if (bus.o_mem_re) bus.i_mem_rdata <= mem[bus.o_mem_addr];

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int          id;
        logic [1:0]  mode;
        logic [15:0] base;
        logic [63:0] hold;
        int          start2;
        int          rst_at;
        bit          count_fill;
        int          exp_done;
        int          exp_nstb;
    } vec_t;

    // Expected timeline of one load, indexed by cycle (cycle 0 = start accepted)
    logic        e_re   [0:127];
    logic [15:0] e_addr [0:127];
    logic [2:0]  e_ws   [0:127];
    logic [7:0]  e_wv   [0:127];
    logic [7:0]  e_w    [0:127];
    logic        e_bn   [0:127];
    logic [7:0]  e_bv   [0:127];
    logic [7:0]  e_b    [0:127];
    logic        e_busy [0:127];
    logic        e_done [0:127];
    logic        e_err  [0:127];
    logic [7:0]  cur_w = 8'h00;
    logic [7:0]  cur_b = 8'h00;

    task automatic check_cycle(input int id, input int c);
        logic [39:0] exp_v, act_v;
        exp_v = {e_re[c], e_re[c] ? e_addr[c] : 16'h0, e_ws[c], e_w[c], e_bn[c], e_b[c],
                 e_busy[c], e_done[c], e_err[c]};
        act_v = {bus.o_mem_re, e_re[c] ? bus.o_mem_addr : 16'h0,
                 bus.o_weight_new, bus.o_weight_new_16, bus.o_weight_new_8, bus.o_weight,
                 bus.o_bias_new, bus.o_bias, bus.o_busy, bus.o_done, bus.o_err};
        vectors++;
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL load%0d cycle %0d outputs: got %h expected %h", id, c, act_v, exp_v);
        end
    endtask

    task automatic check_idle(input string name, input bit with_addr);
        logic [39:0] act_v;
        act_v = {bus.o_mem_re, with_addr ? bus.o_mem_addr : 16'h0,
                 bus.o_weight_new, bus.o_weight_new_16, bus.o_weight_new_8, bus.o_weight,
                 bus.o_bias_new, bus.o_bias, bus.o_busy, bus.o_done, bus.o_err};
        vectors++;
        if (act_v !== 40'h0) begin
            miscompares++;
            $display("FAIL %s: got %h expected 0", name, act_v);
        end
    endtask

    task automatic run_load(input vec_t v);
        int n, t, k, last, done_c, ncyc, done_seen, nstb;
        n = (v.mode == 2'd0) ? 25 : (v.mode == 2'd1) ? 16 : 8;
        for (int c = 0; c < 128; c++) begin
            e_re[c] = 0; e_addr[c] = 0; e_ws[c] = 0; e_wv[c] = 0; e_w[c] = 0; e_bn[c] = 0;
            e_bv[c] = 0; e_b[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
        end
        if (v.mode != 2'd3) begin
            for (int i = 0; i <= n; i++) begin
                logic [15:0] a;
                a = v.base + 16'(i);
                if (!v.count_fill) mem[a] = 8'($urandom);
                else mem[a] = (i == n) ? 8'hA5 : 8'(i + 1);
            end
        end
        // Build the reference timeline from the load rules
        done_c = 0;
        if (v.mode == 2'd3) begin
            e_err[1] = 1'b1;
            ncyc = 4;
        end else begin
            t = 1;
            k = 0;
            while (k <= n) begin
                if (!(t < 64 && v.hold[t])) begin
                    e_re[t]   = 1'b1;
                    e_addr[t] = v.base + 16'(k);
                    if (k < n) begin
                        e_ws[t+2] = (v.mode == 2'd0) ? 3'b100 : (v.mode == 2'd1) ? 3'b010 : 3'b001;
                        e_wv[t+2] = mem[e_addr[t]];
                    end else begin
                        e_bn[t+2] = 1'b1;
                        e_bv[t+2] = mem[e_addr[t]];
                    end
                    k++;
                end
                t++;
            end
            last   = t - 1;
            done_c = last + 3;
            for (int c = 1; c <= done_c; c++) e_busy[c] = 1'b1;
            e_done[done_c] = 1'b1;
            ncyc = done_c + 2;
        end
        if (v.rst_at > 0) ncyc = v.rst_at + 3;
        for (int c = 0; c <= ncyc; c++) begin
            if (v.rst_at > 0 && c > v.rst_at) begin
                e_re[c] = 0; e_ws[c] = 0; e_bn[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
                cur_w = 8'h00;
                cur_b = 8'h00;
            end else begin
                if (e_ws[c] != 3'b000) cur_w = e_wv[c];
                if (e_bn[c]) cur_b = e_bv[c];
            end
            e_w[c] = cur_w;
            e_b[c] = cur_b;
        end

        done_seen = 0;
        nstb = 0;
        for (int c = 0; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            rst_n = !(v.rst_at > 0 && c == v.rst_at);
            bus.i_hold = (c < 64) ? v.hold[c] : 1'b0;
            bus.i_start = 1'b0;
            bus.i_mode = 2'($urandom);
            bus.i_base_addr = 16'($urandom);
            if (c == 0) begin
                bus.i_start = 1'b1;
                bus.i_mode = v.mode;
                bus.i_base_addr = v.base;
            end else if (c == v.start2 && e_busy[c]) begin
                bus.i_start = 1'b1;
            end
            @(negedge clk);
            check_cycle(v.id, c);
            if (bus.o_done && done_seen == 0) done_seen = c;
            if (bus.o_weight_new || bus.o_weight_new_16 || bus.o_weight_new_8) nstb++;
        end
        rst_n = 1'b1;
        if (v.exp_done >= 0) begin
            vectors++;
            if (done_seen != v.exp_done) begin
                miscompares++;
                $display("FAIL load%0d done cycle: got %0d expected %0d", v.id, done_seen, v.exp_done);
            end
        end
        vectors++;
        if (nstb != v.exp_nstb) begin
            miscompares++;
            $display("FAIL load%0d weight strobe count: got %0d expected %0d", v.id, nstb, v.exp_nstb);
        end
        $display("load%0d mode %0d base %h: done at cycle %0d, %0d weight strobes",
                 v.id, v.mode, v.base, done_seen, nstb);
    endtask

    vec_t table_v [0:7];

    initial begin
        //            id mode  base      hold      start2 rst  cnt done nstb
        table_v[0] = '{0, 2'd0, 16'h0100, 64'h0,   0,     0,   1,  29,  25};
        table_v[1] = '{1, 2'd2, 16'h0300, 64'h70,  0,     0,   0,  15,  8};
        table_v[2] = '{2, 2'd1, 16'h0400, 64'h0,   5,     0,   0,  20,  16};
        table_v[3] = '{3, 2'd3, 16'h0500, 64'h0,   0,     0,   0,  0,   0};
        table_v[4] = '{4, 2'd1, 16'hFFFE, 64'h0,   0,     0,   1,  20,  16};
        table_v[5] = '{5, 2'd0, 16'h0600, 64'h0,   0,     10,  0,  0,   8};
        table_v[6] = '{6, 2'd1, 16'h0700, 64'h0,   0,     0,   0,  20,  16};
        table_v[7] = '{7, 2'd2, 16'h1234, 64'h0,   0,     0,   0,  12,  8};

        bus.i_start = 1'b0;
        bus.i_mode = 2'd0;
        bus.i_base_addr = 16'h0;
        bus.i_hold = 1'b0;

        // Reset with random inputs, then idle without a start
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            bus.i_start = 1'($urandom);
            bus.i_mode = 2'($urandom);
            bus.i_base_addr = 16'($urandom);
            bus.i_hold = 1'($urandom);
            @(negedge clk);
            check_idle("reset", 1'b1);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.i_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            bus.i_mode = 2'($urandom);
            bus.i_base_addr = 16'($urandom);
            bus.i_hold = 1'($urandom);
            @(negedge clk);
            check_idle("idle after reset", 1'b0);
            @(posedge clk);
            #1;
        end

        for (int i = 0; i < 8; i++) run_load(table_v[i]);

        for (int i = 0; i < 10; i++) begin
            vec_t rv;
            int n;
            rv.id = 100 + i;
            rv.mode = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            rv.base = 16'($urandom);
            rv.hold = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            rv.start2 = $urandom_range(1, 25);
            rv.rst_at = 0;
            rv.count_fill = 1'b0;
            rv.exp_done = -1;
            n = (rv.mode == 2'd0) ? 25 : (rv.mode == 2'd1) ? 16 : (rv.mode == 2'd2) ? 8 : 0;
            rv.exp_nstb = n;
            run_load(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
